// File: rtl/cas_key_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the CAS-Lock key loader.
// Holds the loader FSM states, frame constants and the CRC-8 (poly 0x07) byte step.
package cas_key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEY    = 2'd1,
        CRC    = 2'd2,
        LOCKED = 2'd3
    } ld_state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] CRC_POLY = 8'h07;

    // MSB-first, init/xorout handled by the caller, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_update.sv
`timescale 1ns/1ps
// Single-byte CRC-8 step, shared with the provisioning-side frame builder.
// Latency: combinational. Backpressure: none.
module crc8_update
    import cas_key_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    assign crc_out = crc8_byte(crc_in, data);

endmodule

// File: rtl/cas_key_loader.sv
`timescale 1ns/1ps
// Framed, CRC-checked key loader driving the keyinput bus of a CAS-Lock core.
// Latency: key/key_valid/load_ok visible the cycle after the matching CRC byte is accepted.
// Backpressure: in_ready decoded from state only; low once locked.
module cas_key_loader
    import cas_key_pkg::*;
#(
    parameter int               KEY_W     = 64,
    parameter logic [KEY_W-1:0] DECOY_KEY = '0,
    parameter bit               LOCK_ONCE = 1'b1,
    parameter int               TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_abort,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             load_ok,
    output logic             load_err,
    output logic             busy
);

    localparam int NB   = KEY_W / 8;
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW   = $clog2(TIMEOUT + 1);

    ld_state_t        state, state_n;
    logic [KEY_W-1:0] shadow, shadow_n, key_n;
    logic [7:0]       crc, crc_n, crc_nx;
    logic [IDXW-1:0]  idx, idx_n;
    logic [IW-1:0]    idle, idle_n;
    logic             kv_n, ok_n, err_n, acc;

    crc8_update u_crc (
        .crc_in  (crc),
        .data    (in_data),
        .crc_out (crc_nx)
    );

    assign in_ready = (state != LOCKED);
    assign acc      = in_valid && in_ready;

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        crc_n    = crc;
        idx_n    = idx;
        idle_n   = idle;
        key_n    = key;
        kv_n     = key_valid;
        ok_n     = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (acc && in_data == HDR_BYTE) begin
                    state_n = KEY;
                    idx_n   = '0;
                    crc_n   = '0;
                    idle_n  = '0;
                end
            end
            KEY, CRC: begin
                // Abort outranks both a coincident byte and a coincident timeout.
                if (in_abort) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (acc) begin
                    idle_n = '0;
                    if (state == KEY) begin
                        shadow_n[{idx, 3'b000} +: 8] = in_data;
                        crc_n = crc_nx;
                        if (idx == IDXW'(NB - 1)) begin
                            state_n = CRC;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else if (in_data == crc) begin
                        key_n   = shadow;
                        kv_n    = 1'b1;
                        ok_n    = 1'b1;
                        state_n = LOCK_ONCE ? LOCKED : IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (idle == IW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    idle_n = idle + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            crc       <= '0;
            idx       <= '0;
            idle      <= '0;
            key       <= DECOY_KEY;
            key_valid <= 1'b0;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            crc       <= crc_n;
            idx       <= idx_n;
            idle      <= idle_n;
            key       <= key_n;
            key_valid <= kv_n;
            load_ok   <= ok_n;
            load_err  <= err_n;
            busy      <= (state_n == KEY) || (state_n == CRC);
        end
    end

endmodule

// File: doc/cas_key_loader.md
# cas_key_loader

Key-provisioning front end for CAS-Lock protected netlists. It receives a framed, CRC-protected key over a byte-serial valid/ready port and assembles it in a shadow register. After the frame verifies, it commits the key atomically and drives the locked block's `keyinput_*` bus with it. It sits between the provisioning interface (test access or secure boot) and the combinational locked core, whose key bits are otherwise unconstrained primary inputs.

## Interface
Parameters:
- `KEY_W`, 64: key width in bits; must be a multiple of 8.
- `DECOY_KEY`, 64'h0: value driven on `key` before any successful commit.
- `LOCK_ONCE`, 1: if 1, the key cannot be reloaded after the first commit until reset.
- `TIMEOUT`, 255: maximum idle cycles allowed between bytes inside a frame.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  8: provisioning byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `in_abort`  in  1: discard the current frame.
- `key`  out  KEY_W: bit i drives `keyinput_i` of the locked core.
- `key_valid`  out  1: `key` holds a committed, verified key.
- `load_ok`  out  1: one-cycle pulse when a frame commits.
- `load_err`  out  1: one-cycle pulse on CRC mismatch, timeout, or abort of a started frame.
- `busy`  out  1: a frame is in progress.

## Operation
- Frame format: header byte 0xA5, then KEY_W/8 key bytes, then one CRC byte.
- Key bytes arrive LSB-first. Byte n maps to `key[8n+7:8n]`.
- CRC: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR. It covers the key bytes only.
- A byte is accepted when `in_valid & in_ready`.
- FSM states:
  - IDLE: accepts any byte. 0xA5 moves to KEY and clears the byte counter and CRC. Any other byte is dropped silently, with no error.
  - KEY: each accepted byte is written into the shadow register and folded into the CRC. After byte KEY_W/8−1, go to CRC.
  - CRC: one accepted byte. On a match, copy shadow to `key`, set `key_valid`, pulse `load_ok`, then go to LOCKED if LOCK_ONCE=1, else IDLE. On a mismatch, pulse `load_err` and go to IDLE; `key` and `key_valid` are unchanged.
  - LOCKED: terminal until `rst`. `in_ready`=0 and all input is ignored.
- `in_ready` = 1 in IDLE, KEY and CRC; 0 in LOCKED.
- `busy` = 1 in KEY and CRC.
- Timeout: in KEY or CRC, an idle counter increments on every cycle without an accepted byte and clears on each accepted byte. When it reaches TIMEOUT, pulse `load_err` and go to IDLE.
- `in_abort`: in KEY or CRC, pulse `load_err` and go to IDLE. In IDLE or LOCKED it has no effect.
- Abort wins over a simultaneous byte; that byte is not consumed. Abort also wins over a simultaneous timeout; only one `load_err` pulse is produced.
- Reload (LOCK_ONCE=0): `key` holds the previously committed value for the whole new frame. Only a verified CRC replaces it, so no partial key is ever visible.

## Timing
- Reset values: `in_ready`=1, `key`=DECOY_KEY, `key_valid`=0, `load_ok`=0, `load_err`=0, `busy`=0. FSM goes to IDLE and the shadow register and CRC clear.
- Reset mid-frame discards the frame and reverts `key` to DECOY_KEY.
- Throughput: one byte per cycle. A complete frame takes KEY_W/8+2 accepted bytes (10 for KEY_W=64).
- `key`, `key_valid` and `load_ok` all update on the clock edge that accepts a matching CRC byte, so they are visible the next cycle.
- `load_err` asserts the cycle after the triggering accept, abort, or timeout edge.
- The timeout fires on the edge where the idle count equals TIMEOUT: exactly TIMEOUT consecutive idle cycles after the last accepted byte.
- All outputs are registered. There are no combinational paths from inputs to outputs except `in_ready`, which is decoded from FSM state only.

## Structure
- Package `cas_key_pkg` holds:
  - the FSM state enum (IDLE, KEY, CRC, LOCKED);
  - `HDR_BYTE`=8'hA5;
  - `CRC_POLY`=8'h07;
  - a pure function `crc8_byte(crc, data)`.
- Sub-module `crc8_update`: a combinational single-byte CRC step wrapping `crc8_byte`, so it can be reused by the provisioning-side frame builder.
- Counters: byte index of width $clog2(KEY_W/8); idle counter of width $clog2(TIMEOUT+1).

## Test plan
- Reset, then frame A5, eight 0x00, 00 → `key`=0, `key_valid`=1, one `load_ok` pulse; `in_ready` is 0 afterwards (LOCK_ONCE=1).
- Frame A5, eight 0x00, CRC 0x01 → one `load_err` pulse; `key` stays DECOY_KEY; `key_valid`=0.
- Bytes 3C, 11 in IDLE, then a valid frame for key 64'h0123456789ABCDEF (CRC from the software model) → junk is ignored, no `load_err`; `key`=64'h0123456789ABCDEF.
- LOCK_ONCE=0: commit key K1, then stream a K2 frame with a 3-cycle gap mid-frame → `key`=K1 until the CRC edge, then K2.
- TIMEOUT=4: header plus 2 key bytes, then 4 idle cycles → `load_err` pulse, `busy`=0. Also `in_abort` coinciding with a valid key byte → single `load_err`, byte not consumed.
- `rst` after 5 key bytes → all outputs return to reset values; a fresh frame then commits normally.
